packet_receiver: RTL
====================

Name: packet_receiver

Overview:
- Receive side of the router's byte-serial packet link: the far-end counterpart of the packet transmitter.
- Accepts a packet_valid-qualified byte stream in the order SRC_ID, DST_ID, SIZE, DATA[0..N-1], CRC.
- Checks framing and checksum, then writes the whole packet into one slot of the input packet buffer and commits that slot.
- Sits between the link input and the input buffer write port (we/waddr/wdata/winc/wfull).

Parameters:
UWIDTH, 8, link/buffer byte width
PTR_IN_SZ, 4, buffer slot address width; requires 4+(2^SIZE_BITS-1) <= 2^PTR_IN_SZ
SIZE_BITS, 3, width of the length field in the SIZE byte (N = SIZE[SIZE_BITS-1:0])

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous active-low reset
packet_valid  in  1  qualifies packet_in; high for every byte of a packet
packet_in  in  UWIDTH  packet byte
wfull  in  1  buffer has no free slot
we  out  1  slot byte write strobe
waddr  out  PTR_IN_SZ  byte offset within current slot
wdata  out  UWIDTH  byte to write
winc  out  1  commit current slot (one-cycle pulse)
pkt_drop  out  1  one-cycle pulse: packet discarded because buffer full
pkt_err  out  1  one-cycle pulse: length, truncation or CRC error

Behaviour:
- Reset (async, rst=0): state IDLE; we, winc, pkt_drop, pkt_err, waddr, wdata = 0; checksum and count = 0.
- All outputs are registered. The byte sampled at edge k appears as we=1/waddr/wdata after edge k (1-cycle latency).
- Upstream drives bytes on the falling edge; the receiver samples on the rising edge.
- Checksum: running XOR of SRC, DST, SIZE and all DATA bytes, UWIDTH wide.
- States: IDLE, DST, SIZE, DATA, CRC, DROP.
- IDLE, valid=0: stay in IDLE.
- IDLE, valid=1, wfull=0: write offset 0, chk=byte, go to DST.
- IDLE, valid=1, wfull=1: pkt_drop pulse, go to DROP. wfull is sampled only in IDLE, on the SRC byte.
- DST: valid=1 -> write offset 1, go to SIZE.
- SIZE: valid=1, N=0 -> pkt_err, go to DROP, no write. Otherwise write offset 2, cnt=N, go to DATA.
- DATA: valid=1 -> write offset 2+(N-cnt+1), cnt-=1; when cnt reaches 0, go to CRC.
- CRC, valid=1: write offset 3+N. On the same edge, winc=1 if byte==chk; else winc=0 and pkt_err=1. Go to IDLE.
- Commit contract: the buffer applies the last write and the commit on the same edge.
- valid=0 in DST, SIZE, DATA or CRC (truncation): pkt_err pulse, go to IDLE, no winc. The partial slot is overwritten by the next packet.
- DROP: no writes; stay while valid=1; go to IDLE on the first cycle with valid=0.
- Back-to-back packets: a byte with valid=1 on the edge after the CRC byte is taken as the next SRC. No idle gap is required.
- wfull changing mid-packet has no effect.
- Reset mid-packet: the packet is lost; no winc is issued.
- pkt_drop and pkt_err never assert on the same edge.

Optional Feature:
CRC_CHECK_EN
- Defined: CRC compared as above; mismatch -> no winc, pkt_err pulse.
- Undefined: the CRC byte is written and winc=1 unconditionally. No checksum logic is generated; pkt_err covers only length and truncation errors.

Test Plan:
- Good packet, valid continuous: 01,02,02,A5,5A,FE -> we at offsets 0..5 with those bytes; winc=1 on the FE write edge; no pkt_err.
- Same packet with CRC=00 -> all 6 bytes written, winc=0, pkt_err one-cycle pulse. With CRC_CHECK_EN undefined: winc=1.
- wfull=1 at SRC byte, then packet 01,02,01,33,31 -> pkt_drop pulse once, no we/winc. Next packet after valid=0 is accepted normally.
- SIZE=0x08 (N=0 with SIZE_BITS=3) -> pkt_err after the SIZE byte; no write of offset 2; the remaining bytes are ignored until valid drops.
- Truncation: valid drops after DATA[0] of an N=3 packet -> pkt_err pulse, no winc; the following complete packet commits normally.
- Two back-to-back valid packets with no gap -> two winc pulses, offsets restart at 0. Async reset asserted mid-DATA -> all outputs 0 immediately, no winc.

Source files
------------

// File: rtl/packet_receiver_if.sv
// -----------------------------------------------------------------------------
// packet_receiver_if
// Bundle of link-input, buffer-write and status signals around the packet
// receiver.
//   packet_valid / packet_in : byte-serial link from the far-end transmitter
//   wfull                    : input buffer has no free slot
//   we / waddr / wdata       : byte write into the current buffer slot
//   winc                     : commit the current slot (one-cycle pulse)
//   pkt_drop / pkt_err       : one-cycle status pulses
// Modports:
//   master : link driver and buffer side (drives link inputs and wfull)
//   slave  : the receiver (drives buffer writes and status)
// -----------------------------------------------------------------------------
interface packet_receiver_if #(
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4
);
  logic                 packet_valid;
  logic [UWIDTH-1:0]    packet_in;
  logic                 wfull;
  logic                 we;
  logic [PTR_IN_SZ-1:0] waddr;
  logic [UWIDTH-1:0]    wdata;
  logic                 winc;
  logic                 pkt_drop;
  logic                 pkt_err;

  modport master (
    output packet_valid, packet_in, wfull,
    input  we, waddr, wdata, winc, pkt_drop, pkt_err
  );

  modport slave (
    input  packet_valid, packet_in, wfull,
    output we, waddr, wdata, winc, pkt_drop, pkt_err
  );
endinterface

// File: rtl/packet_receiver.sv
// -----------------------------------------------------------------------------
// packet_receiver
// Receive side of the byte-serial packet link. Takes SRC, DST, SIZE,
// DATA[0..N-1], CRC, checks framing (and optionally the XOR checksum), writes
// the packet into one input-buffer slot and commits it with winc on the same
// edge as the last byte write.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : packet_receiver_if.slave (link input, buffer write port, status)
//
// Build option:
//   CRC_CHECK_EN : when defined, the CRC byte is compared against the running
//                  XOR of SRC, DST, SIZE and DATA; a mismatch suppresses winc
//                  and pulses pkt_err. When undefined, no checksum logic is
//                  built and every framed packet is committed.
//
// State  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for a SRC byte; wfull sampled here only
// DST    | expecting DST byte (offset 1)
// SIZE   | expecting SIZE byte (offset 2); N = 0 is a length error
// DATA   | receiving N data bytes (offsets 3..2+N)
// CRC    | expecting CRC byte (offset 3+N); commit on this edge
// DROP   | discarding bytes until packet_valid drops
// -----------------------------------------------------------------------------
module packet_receiver #(
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4,
  parameter int SIZE_BITS = 3
) (
  input logic              clk,
  input logic              rst,
  packet_receiver_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DST  = 3'd1,
    S_SIZE = 3'd2,
    S_DATA = 3'd3,
    S_CRC  = 3'd4,
    S_DROP = 3'd5
  } state_t;

  localparam logic [PTR_IN_SZ-1:0] ADDR_ONE = PTR_IN_SZ'(1);
  localparam logic [SIZE_BITS-1:0] CNT_ONE  = SIZE_BITS'(1);

  state_t               r_state, w_state_nxt;
  logic [SIZE_BITS-1:0] r_cnt, w_cnt_nxt;
  logic [PTR_IN_SZ-1:0] r_waddr, w_waddr_nxt;
  logic [UWIDTH-1:0]    r_wdata, w_wdata_nxt;
  logic                 r_we, w_we_nxt;
  logic                 r_winc, w_winc_nxt;
  logic                 r_drop, w_drop_nxt;
  logic                 r_err, w_err_nxt;

  logic [SIZE_BITS-1:0] w_size_n;
  logic [PTR_IN_SZ-1:0] w_addr_inc;
  logic                 w_crc_ok;

  assign w_size_n   = bus.packet_in[SIZE_BITS-1:0];
  // Writes within a packet are at consecutive offsets, so every byte after
  // SRC lands one past the previous write.
  assign w_addr_inc = r_waddr + ADDR_ONE;

`ifdef CRC_CHECK_EN
  logic [UWIDTH-1:0] r_chk, w_chk_nxt;

  // Reload on the SRC write, accumulate on every later write. The CRC byte is
  // also folded in, which is harmless because the next SRC reloads.
  always_comb begin
    w_chk_nxt = r_chk;
    if (w_we_nxt) begin
      w_chk_nxt = (r_state == S_IDLE) ? bus.packet_in : (r_chk ^ bus.packet_in);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_chk <= '0;
    else      r_chk <= w_chk_nxt;
  end

  assign w_crc_ok = (bus.packet_in == r_chk);
`else
  assign w_crc_ok = 1'b1;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_winc  <= 1'b0;
      r_drop  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
      r_we    <= w_we_nxt;
      r_winc  <= w_winc_nxt;
      r_drop  <= w_drop_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.packet_valid) w_state_nxt = bus.wfull ? S_DROP : S_DST;
      S_DST:  w_state_nxt = bus.packet_valid ? S_SIZE : S_IDLE;
      S_SIZE: begin
        if (!bus.packet_valid)     w_state_nxt = S_IDLE;
        else if (w_size_n == '0)   w_state_nxt = S_DROP;
        else                       w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (!bus.packet_valid)     w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_ONE) w_state_nxt = S_CRC;
        else                       w_state_nxt = S_DATA;
      end
      S_CRC:  w_state_nxt = S_IDLE;
      S_DROP: w_state_nxt = bus.packet_valid ? S_DROP : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values. Strobes default low so they pulse for one
  // cycle; waddr/wdata hold their last value between writes.
  always_comb begin
    w_we_nxt    = 1'b0;
    w_winc_nxt  = 1'b0;
    w_drop_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_waddr_nxt = r_waddr;
    w_wdata_nxt = r_wdata;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.packet_valid) begin
          if (bus.wfull) begin
            w_drop_nxt = 1'b1;
          end else begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = '0;
            w_wdata_nxt = bus.packet_in;
          end
        end
      end
      S_DST: begin
        if (bus.packet_valid) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = w_addr_inc;
          w_wdata_nxt = bus.packet_in;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      S_SIZE: begin
        if (!bus.packet_valid || (w_size_n == '0)) begin
          w_err_nxt = 1'b1;
        end else begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = w_addr_inc;
          w_wdata_nxt = bus.packet_in;
          w_cnt_nxt   = w_size_n;
        end
      end
      S_DATA: begin
        if (bus.packet_valid) begin
          w_we_nxt    = 1'b1;
          w_waddr_nxt = w_addr_inc;
          w_wdata_nxt = bus.packet_in;
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      S_CRC: begin
        if (bus.packet_valid) begin
          // Last write and commit share the edge; the buffer relies on this.
          w_we_nxt    = 1'b1;
          w_waddr_nxt = w_addr_inc;
          w_wdata_nxt = bus.packet_in;
          w_winc_nxt  = w_crc_ok;
          w_err_nxt   = !w_crc_ok;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.we       = r_we;
  assign bus.waddr    = r_waddr;
  assign bus.wdata    = r_wdata;
  assign bus.winc     = r_winc;
  assign bus.pkt_drop = r_drop;
  assign bus.pkt_err  = r_err;

endmodule
